bouncing_box_renderer: RTL and testbench
========================================

# bouncing_box_renderer

Pixel-colour stage driven directly by the VGA controller's outputs (800×600 active, 1040×666 total, 50 MHz pixel clock). It draws a bordered background with a solid square that moves a fixed step once per frame and bounces off the active-area edges. RGB is registered, and the controller's sync and blank signals are delayed one cycle so that they stay aligned with the RGB data at the DAC.

## Interface
Parameters:
- `H_ACTIVE`, 800, active pixels per line
- `V_ACTIVE`, 600, active lines per frame
- `BOX_SIZE`, 32, box edge length in pixels
- `STEP`, 2, pixels moved per frame on each axis (1 ≤ STEP < BOX_SIZE)
- `BORDER`, 4, width of the screen-edge border in pixels
- `BOX_COLOUR`, 24'hFF0000, box colour {R,G,B}
- `BORDER_COLOUR`, 24'hFFFFFF, border colour
- `BG_COLOUR`, 24'h000040, background colour

Ports:
- `Clock` in 1: 50 MHz pixel clock
- `Reset` in 1: asynchronous, active-high
- `Enable` in 1: when 0, box position is frozen; drawing continues
- `nextX` in 11: x coordinate of the current pixel
- `nextY` in 10: y coordinate of the current pixel
- `blank_n_in`, `hSync_n_in`, `vSync_n_in`, `sync_n_in` in 1 each: from the controller
- `red`, `green`, `blue` out 8 each: registered pixel colour
- `blank_n`, `hSync_n`, `vSync_n`, `sync_n` out 1 each: inputs delayed one cycle
- `frameTick` out 1: one-cycle pulse on each detected frame boundary
- `bounceCount` out 8: count of ticks on which a reversal occurred, wraps at 255→0

## Operation
- State registers: `boxX[10:0]`, `boxY[9:0]`, `dirX`, `dirY` (1 = increasing), `vsPrev`.
- Reset values: boxX=0, boxY=0, dirX=dirY=1, vsPrev=1.
- Output reset values: RGB=0, blank_n=0, hSync_n=1, vSync_n=1, sync_n=1, frameTick=0, bounceCount=0.
- Frame tick: `vsPrev==1 && vSync_n_in==0`, i.e. the falling edge of vSync_n_in. vsPrev is updated every cycle.
  - `frameTick` is registered and asserts in the cycle after the edge, regardless of Enable.
- Position update (X shown; Y is identical with V_ACTIVE), applied only on a tick with Enable=1:
  - dirX=1: if boxX+STEP ≥ H_ACTIVE−BOX_SIZE, set boxX=H_ACTIVE−BOX_SIZE and dirX=0; else boxX += STEP.
  - dirX=0: if boxX ≤ STEP, set boxX=0 and dirX=1; else boxX −= STEP.
  - Arithmetic uses 12-bit/11-bit intermediates, so no wrap-around is possible. The box never leaves [0, H_ACTIVE−BOX_SIZE].
- bounceCount increments by 1 on a tick where dirX, dirY or both flip. A corner bounce (both flip) counts once.
- Colour priority (evaluated on the inputs, registered to the outputs):
  1. blank_n_in==0 → 0.
  2. boxX ≤ nextX < boxX+BOX_SIZE and boxY ≤ nextY < boxY+BOX_SIZE → BOX_COLOUR.
  3. nextX < BORDER, nextX ≥ H_ACTIVE−BORDER, nextY < BORDER, or nextY ≥ V_ACTIVE−BORDER → BORDER_COLOUR.
  4. Otherwise → BG_COLOUR.
- The box is drawn over the border.

## Timing
- Latency is exactly 1 cycle from (nextX, nextY, blank/sync inputs) to (RGB, blank/sync outputs). All outputs are registered.
- Position updates occur during vertical sync, which is blanked, so a frame never shows a partially moved box.
- A tick and a bounce in the same cycle: the new position and direction take effect together. bounceCount and frameTick update in the same cycle as the position.
- Enable deasserted at a tick: no movement and no bounceCount change, but frameTick still pulses.
- Reset asserted mid-frame: all state and outputs go to their reset values immediately. After release, the first vSync falling edge is the first tick.
- vSync_n_in held low for many cycles yields only one tick.

## Test plan
- **Reset mid-operation:** assert Reset with the box at (100,50) → RGB=0, blank_n=0, hSync_n=vSync_n=sync_n=1, bounceCount=0, box at (0,0) on the next active frame.
- **Pixel alignment:** blank_n_in=1, box at (0,0), drive nextX=10, nextY=10 → cycle+1 shows RGB=FF/00/00 and blank_n=1. Drive nextX=400, nextY=2 → BORDER_COLOUR. Drive nextX=400, nextY=300 → 00/00/40. Drive blank_n_in=0 → RGB=0.
- **Right-edge bounce:** drive synthetic vSync pulses with Enable=1. After 384 ticks boxX=768, dirX=0, bounceCount=0. Tick 284 is the Y bounce (boxY=568) → bounceCount=1 at that tick. Tick 384 → bounceCount=2. Tick 385 → boxX=766.
- **Enable gating:** Enable=0 over 10 ticks → boxX and boxY unchanged, frameTick pulses 10 times.
- **Corner bounce:** Y size equal to X range (override V_ACTIVE=800) → both axes flip on tick 384 and bounceCount increments by exactly 1.
- **Wrap:** 256 bounces → bounceCount returns to 0. A long vSync_n_in low (1000 cycles) → a single frameTick.

Source files
------------

// File: rtl/bouncing_box_renderer.sv
// Pixel-colour stage for an 800x600 VGA timing: bordered background plus a square
// that steps once per frame and bounces off the active-area edges.
module bouncing_box_renderer #(
  parameter int unsigned H_ACTIVE      = 32'd800,
  parameter int unsigned V_ACTIVE      = 32'd600,
  parameter int unsigned BOX_SIZE      = 32'd32,
  parameter int unsigned STEP          = 32'd2,
  parameter int unsigned BORDER        = 32'd4,
  parameter logic [23:0] BOX_COLOUR    = 24'hFF0000,
  parameter logic [23:0] BORDER_COLOUR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOUR     = 24'h000040
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [10:0] nextX,
  input  logic [9:0]  nextY,
  input  logic        blank_n_in,
  input  logic        hSync_n_in,
  input  logic        vSync_n_in,
  input  logic        sync_n_in,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        blank_n,
  output logic        hSync_n,
  output logic        vSync_n,
  output logic        sync_n,
  output logic        frameTick,
  output logic [7:0]  bounceCount
);

  localparam logic [10:0] X_LIMIT     = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_LIMIT     = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] STEP_W12    = 12'(STEP);
  localparam logic [10:0] STEP_W11    = 11'(STEP);
  localparam logic [9:0]  STEP_W10    = 10'(STEP);
  localparam logic [11:0] BOX_W12     = 12'(BOX_SIZE);
  localparam logic [10:0] BOX_W11     = 11'(BOX_SIZE);
  localparam logic [10:0] BORDER_X_LO = 11'(BORDER);
  localparam logic [10:0] BORDER_X_HI = 11'(H_ACTIVE - BORDER);
  localparam logic [9:0]  BORDER_Y_LO = 10'(BORDER);
  localparam logic [9:0]  BORDER_Y_HI = 10'(V_ACTIVE - BORDER);

  logic [10:0] box_x_r;
  logic [9:0]  box_y_r;
  logic        dir_x_r;
  logic        dir_y_r;
  logic        vs_prev_r;

  logic        tick_s;
  logic [11:0] sum_x_s;
  logic [10:0] sum_y_s;
  logic [10:0] next_box_x_s;
  logic [9:0]  next_box_y_s;
  logic        next_dir_x_s;
  logic        next_dir_y_s;
  logic        flip_x_s;
  logic        flip_y_s;
  logic        in_box_s;
  logic        in_border_s;
  logic [23:0] colour_s;

  assign tick_s = vs_prev_r & ~vSync_n_in;

  // Horizontal step with clamp-and-reverse at either edge; wide sum keeps it wrap-free
  always_comb begin
    sum_x_s      = {1'b0, box_x_r} + STEP_W12;
    next_box_x_s = box_x_r;
    next_dir_x_s = dir_x_r;
    flip_x_s     = 1'b0;
    if (dir_x_r) begin
      if (sum_x_s >= {1'b0, X_LIMIT}) begin
        next_box_x_s = X_LIMIT;
        next_dir_x_s = 1'b0;
        flip_x_s     = 1'b1;
      end else begin
        next_box_x_s = sum_x_s[10:0];
      end
    end else begin
      if (box_x_r <= STEP_W11) begin
        next_box_x_s = 11'd0;
        next_dir_x_s = 1'b1;
        flip_x_s     = 1'b1;
      end else begin
        next_box_x_s = box_x_r - STEP_W11;
      end
    end
  end

  // Vertical step, same rule as horizontal
  always_comb begin
    sum_y_s      = {1'b0, box_y_r} + STEP_W11;
    next_box_y_s = box_y_r;
    next_dir_y_s = dir_y_r;
    flip_y_s     = 1'b0;
    if (dir_y_r) begin
      if (sum_y_s >= {1'b0, Y_LIMIT}) begin
        next_box_y_s = Y_LIMIT;
        next_dir_y_s = 1'b0;
        flip_y_s     = 1'b1;
      end else begin
        next_box_y_s = sum_y_s[9:0];
      end
    end else begin
      if (box_y_r <= STEP_W10) begin
        next_box_y_s = 10'd0;
        next_dir_y_s = 1'b1;
        flip_y_s     = 1'b1;
      end else begin
        next_box_y_s = box_y_r - STEP_W10;
      end
    end
  end

  // Pixel classification; the box wins over the border
  always_comb begin
    in_box_s = ({1'b0, nextX} >= {1'b0, box_x_r}) &&
               ({1'b0, nextX} <  ({1'b0, box_x_r} + BOX_W12)) &&
               ({1'b0, nextY} >= {1'b0, box_y_r}) &&
               ({1'b0, nextY} <  ({1'b0, box_y_r} + BOX_W11));
    in_border_s = (nextX < BORDER_X_LO) || (nextX >= BORDER_X_HI) ||
                  (nextY < BORDER_Y_LO) || (nextY >= BORDER_Y_HI);
    if (!blank_n_in) begin
      colour_s = 24'h000000;
    end else if (in_box_s) begin
      colour_s = BOX_COLOUR;
    end else if (in_border_s) begin
      colour_s = BORDER_COLOUR;
    end else begin
      colour_s = BG_COLOUR;
    end
  end

  // Frame-edge detect, box motion and bounce counter
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      box_x_r     <= 11'd0;
      box_y_r     <= 10'd0;
      dir_x_r     <= 1'b1;
      dir_y_r     <= 1'b1;
      vs_prev_r   <= 1'b1;
      frameTick   <= 1'b0;
      bounceCount <= 8'd0;
    end else begin
      vs_prev_r <= vSync_n_in;
      frameTick <= tick_s;
      if (tick_s && Enable) begin
        box_x_r <= next_box_x_s;
        box_y_r <= next_box_y_s;
        dir_x_r <= next_dir_x_s;
        dir_y_r <= next_dir_y_s;
        if (flip_x_s || flip_y_s) begin
          bounceCount <= bounceCount + 8'd1;
        end
      end
    end
  end

  // Colour and delayed controller strobes, kept aligned for the DAC
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      red     <= 8'd0;
      green   <= 8'd0;
      blue    <= 8'd0;
      blank_n <= 1'b0;
      hSync_n <= 1'b1;
      vSync_n <= 1'b1;
      sync_n  <= 1'b1;
    end else begin
      red     <= colour_s[23:16];
      green   <= colour_s[15:8];
      blue    <= colour_s[7:0];
      blank_n <= blank_n_in;
      hSync_n <= hSync_n_in;
      vSync_n <= vSync_n_in;
      sync_n  <= sync_n_in;
    end
  end

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Bench for bouncing_box_renderer: three parameterisations share one stimulus stream
// and are checked every cycle against a triangle-wave position model.
module tb_bouncing_box_renderer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic        blank_n_in, hSync_n_in, vSync_n_in, sync_n_in;

  logic [2:0][7:0] red_w, green_w, blue_w, bc_w;
  logic [2:0]      blank_w, hs_w, vs_w, ss_w, ft_w;

  int total = 0;
  int bad   = 0;
  int ft_count = 0;

  always #10 Clock = ~Clock;

  bouncing_box_renderer u0 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .nextX(nextX), .nextY(nextY),
    .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in), .vSync_n_in(vSync_n_in), .sync_n_in(sync_n_in),
    .red(red_w[0]), .green(green_w[0]), .blue(blue_w[0]), .blank_n(blank_w[0]), .hSync_n(hs_w[0]),
    .vSync_n(vs_w[0]), .sync_n(ss_w[0]), .frameTick(ft_w[0]), .bounceCount(bc_w[0]));

  bouncing_box_renderer #(.V_ACTIVE(32'd800)) u1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .nextX(nextX), .nextY(nextY),
    .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in), .vSync_n_in(vSync_n_in), .sync_n_in(sync_n_in),
    .red(red_w[1]), .green(green_w[1]), .blue(blue_w[1]), .blank_n(blank_w[1]), .hSync_n(hs_w[1]),
    .vSync_n(vs_w[1]), .sync_n(ss_w[1]), .frameTick(ft_w[1]), .bounceCount(bc_w[1]));

  bouncing_box_renderer #(.H_ACTIVE(32'd36), .V_ACTIVE(32'd36)) u2 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .nextX(nextX), .nextY(nextY),
    .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in), .vSync_n_in(vSync_n_in), .sync_n_in(sync_n_in),
    .red(red_w[2]), .green(green_w[2]), .blue(blue_w[2]), .blank_n(blank_w[2]), .hSync_n(hs_w[2]),
    .vSync_n(vs_w[2]), .sync_n(ss_w[2]), .frameTick(ft_w[2]), .bounceCount(bc_w[2]));

  // Model: position after n moves is a triangle wave of n*STEP over [0, extent-BOX]
  int h_a[3] = '{800, 800, 36};
  int v_a[3] = '{600, 800, 36};
  int n_m[3];
  int cnt_m[3];
  logic [23:0] exp_rgb[3];
  logic [3:0]  exp_sync;
  logic        exp_ft;
  logic        vs_prev_m;
  wire         tick_m = vs_prev_m & ~vSync_n_in;

  function automatic int box_pos(int n, int extent);
    int lim, m;
    lim = extent - 32;
    m = (n * 2) % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic bit is_bounce(int k, int h, int v);
    return ((k * 2) % (h - 32) == 0) || ((k * 2) % (v - 32) == 0);
  endfunction

  function automatic logic [23:0] colour(int x, int y, int bx, int by, logic b, int h, int v);
    if (!b) return 24'h000000;
    if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 24'hFF0000;
    if (x < 4 || x >= h - 4 || y < 4 || y >= v - 4) return 24'hFFFFFF;
    return 24'h000040;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vs_prev_m <= 1'b1;
      exp_sync  <= 4'b0111;
      exp_ft    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_m[i] <= 0;
        cnt_m[i] <= 0;
        exp_rgb[i] <= 24'h000000;
      end
    end else begin
      vs_prev_m <= vSync_n_in;
      exp_ft    <= tick_m;
      exp_sync  <= {blank_n_in, hSync_n_in, vSync_n_in, sync_n_in};
      for (int i = 0; i < 3; i++) begin
        exp_rgb[i] <= colour(int'(nextX), int'(nextY), box_pos(n_m[i], h_a[i]),
                             box_pos(n_m[i], v_a[i]), blank_n_in, h_a[i], v_a[i]);
        if (tick_m && Enable) begin
          n_m[i] <= n_m[i] + 1;
          if (is_bounce(n_m[i] + 1, h_a[i], v_a[i])) cnt_m[i] <= (cnt_m[i] + 1) % 256;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      if (bad <= 30) $display("FAIL %s at %0t: got %0h required %0h", nm, $time, got, req);
    end
  endtask

  task automatic drive_px(input int x, input int y, input logic b);
    @(negedge Clock);
    nextX = 11'(x);
    nextY = 10'(y);
    blank_n_in = b;
    @(posedge Clock);
    #2;
  endtask

  task automatic rand_px();
    int x, y;
    x = box_pos(n_m[0], 800) + int'($urandom_range(0, 39)) - 4;
    y = box_pos(n_m[0], 600) + int'($urandom_range(0, 39)) - 4;
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    nextX = 11'(x);
    nextY = 10'(y);
    blank_n_in = ($urandom_range(0, 7) != 0);
    hSync_n_in = 1'($urandom_range(0, 1));
    sync_n_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic vs_tick();
    @(negedge Clock);
    vSync_n_in = 1'b0;
    rand_px();
    @(negedge Clock);
    vSync_n_in = 1'b1;
    rand_px();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rgb"}, {red_w[0], green_w[0], blue_w[0]}, 24'h000000);
    check({nm, "_syncs"}, {blank_w[0], hs_w[0], vs_w[0], ss_w[0]}, 4'b0111);
    check({nm, "_ft_bc"}, {ft_w[0], bc_w[0]}, 9'd0);
  endtask

  initial begin
    int snap;
    Reset = 1'b1; Enable = 1'b1; nextX = 11'd0; nextY = 10'd0;
    blank_n_in = 1'b1; hSync_n_in = 1'b1; vSync_n_in = 1'b1; sync_n_in = 1'b1;

    // Per-cycle comparison of every instance against the model
    fork
      forever begin
        @(posedge Clock);
        #1;
        if (ft_w[0]) ft_count++;
        for (int i = 0; i < 3; i++)
          check($sformatf("cycle_u%0d", i),
                {red_w[i], green_w[i], blue_w[i], blank_w[i], hs_w[i], vs_w[i], ss_w[i], ft_w[i], bc_w[i]},
                {exp_rgb[i], exp_sync, exp_ft, 8'(cnt_m[i])});
      end
    join_none

    @(posedge Clock); #2;
    check_reset_outputs("reset");
    @(negedge Clock); Reset = 1'b0;

    drive_px(10, 10, 1'b1);
    check("px_box", {red_w[0], green_w[0], blue_w[0], blank_w[0]}, {24'hFF0000, 1'b1});
    drive_px(400, 2, 1'b1);
    check("px_border", {red_w[0], green_w[0], blue_w[0]}, 24'hFFFFFF);
    drive_px(400, 300, 1'b1);
    check("px_bg", {red_w[0], green_w[0], blue_w[0]}, 24'h000040);
    drive_px(400, 300, 1'b0);
    check("px_blank", {red_w[0], green_w[0], blue_w[0], blank_w[0]}, {24'h000000, 1'b0});

    for (int t = 1; t <= 512; t++) begin
      vs_tick();
      if (t == 283) check("bc_t283", bc_w[0], 8'd0);
      if (t == 284) check("bc_t284", bc_w[0], 8'd1);
      if (t == 384) begin
        check("bc_t384", bc_w[0], 8'd2);
        check("model_x384", 64'(box_pos(n_m[0], 800)), 64'd768);
        check("corner_bc", bc_w[1], 8'd1);
        drive_px(768, 368, 1'b1);
        check("probe_in", {red_w[0], green_w[0], blue_w[0]}, 24'hFF0000);
        drive_px(767, 368, 1'b1);
        check("probe_out", {red_w[0], green_w[0], blue_w[0]}, 24'h000040);
      end
      if (t == 385) check("model_x385", 64'(box_pos(n_m[0], 800)), 64'd766);
      if (t == 510) check("wrap_255", bc_w[2], 8'd255);
      if (t == 512) check("wrap_0", bc_w[2], 8'd0);
    end

    Enable = 1'b0;
    snap = ft_count;
    for (int t = 0; t < 10; t++) vs_tick();
    repeat (2) @(negedge Clock);
    check("gate_ticks", 64'(ft_count - snap), 64'd10);
    check("gate_bc", bc_w[0], 8'd2);
    Enable = 1'b1;

    snap = ft_count;
    @(negedge Clock); vSync_n_in = 1'b0;
    repeat (1000) @(negedge Clock);
    vSync_n_in = 1'b1;
    repeat (3) @(negedge Clock);
    check("long_vs_ticks", 64'(ft_count - snap), 64'd1);

    drive_px(box_pos(n_m[0], 800), box_pos(n_m[0], 600), 1'b1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    drive_px(0, 0, 1'b1);
    check("post_reset_box", {red_w[0], green_w[0], blue_w[0]}, 24'hFF0000);
    drive_px(31, 31, 1'b1);
    check("post_reset_corner", {red_w[0], green_w[0], blue_w[0]}, 24'hFF0000);
    drive_px(32, 32, 1'b1);
    check("post_reset_bg", {red_w[0], green_w[0], blue_w[0], bc_w[0]}, {24'h000040, 8'd0});

    repeat (2) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
